// File: rtl/regwrite_demux_if.sv
// Write-back request / register-file write-port bundle for regwrite_demux.
// Signals:
//   in_valid, in_addr, in_data  : write-back request (master -> slave)
//   in_ready                    : request accepted when in_valid && in_ready
//   out_ready                   : register file can take a write (master -> slave)
//   out_valid, wr_en, wr_addr,
//   wr_data                     : head write presented to the register file
// Modports: slave = the demux, master = the environment driving/consuming it.
interface regwrite_demux_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned N = 2 ** ADDR_W;

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic [N-1:0]      wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regwrite_demux.sv
// Write-back demultiplexer for the register file write port.
// Buffers {addr, data} requests in a 2-entry FIFO and presents the head entry
// with a one-hot per-register write-enable vector.
// Ports:
//   clk   : clock, all state updates on rising edge
//   reset : asynchronous active-low reset
//   bus   : regwrite_demux_if.slave (request handshake + register-file side)
// Optional build macro: REGWRITE_ZERO_REG_DROP_EN -- requests addressed to
// register N-1 (XZR) are accepted but discarded instead of buffered.
module regwrite_demux #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  regwrite_demux_if.slave    bus
);
  localparam int unsigned N = 2 ** ADDR_W;

  logic [ADDR_W-1:0] mem_addr [2];
  logic [DATA_W-1:0] mem_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic accept;
  logic push;
  logic pop;
  logic is_xzr;

`ifdef REGWRITE_ZERO_REG_DROP_EN
  assign is_xzr = (bus.in_addr == '1);
`else
  assign is_xzr = 1'b0;
`endif

  // Handshake depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);

  assign accept = bus.in_valid && bus.in_ready;
  // A dropped XZR write completes the handshake but never enters storage.
  assign push   = accept && !is_xzr;
  assign pop    = bus.out_valid && bus.out_ready;

  assign bus.wr_addr = mem_addr[rd_ptr];
  assign bus.wr_data = mem_data[rd_ptr];

  always_comb begin
    bus.wr_en = '0;
    if (bus.out_valid) begin
      bus.wr_en[bus.wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= bus.in_addr;
        mem_data[wr_ptr] <= bus.in_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/regwrite_demux.md
# regwrite_demux

Write-back demultiplexer for the 32-entry register file. It accepts one write request per cycle (address + data) over a valid/ready handshake and buffers it in a 2-entry FIFO. It drives a one-hot per-register write-enable vector with the data, so each register's enable comes from one decoded line rather than a shared address compare. It sits between the write-back stage and the register file write port and is the distribution counterpart of the register file's read-select muxes.

## Interface
Parameters:
- ADDR_W, 5, register address width; number of destination registers N = 2**ADDR_W
- DATA_W, 64, write data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately, deassert is synchronous to clk
- in_valid  input  1  write-back request present
- in_addr  input  ADDR_W  destination register index
- in_data  input  DATA_W  write data
- in_ready  output  1  request accepted on an edge where in_valid && in_ready
- out_ready  input  1  register file can take a write this cycle
- out_valid  output  1  head entry presented on outputs
- wr_en  output  N  one-hot enable; bit wr_addr set iff out_valid, else all zero
- wr_addr  output  ADDR_W  head entry address
- wr_data  output  DATA_W  head entry data

## Operation
- Storage: 2-entry FIFO of {addr, data}, read pointer, write pointer (1 bit each), occupancy count 0..2.
- Push: edge where in_valid && in_ready; entry written at write pointer, pointer toggles.
- Pop: edge where out_valid && out_ready; read pointer toggles.
- in_ready = (count != 2); depends only on registered count, never combinationally on out_ready.
- out_valid = (count != 0); wr_addr/wr_data = entry at read pointer; wr_en = out_valid ? (1 << wr_addr) : 0.
- Count: push only +1, pop only -1, both or neither unchanged.
- Simultaneous push and pop at count 1: both occur, count stays 1, new entry becomes head next cycle.
- Push at count 2 cannot occur (in_ready low); pop at count 2 raises in_ready the following cycle.
- Pop at count 0 cannot occur (out_valid low); out_ready is ignored.
- Order strictly FIFO; no coalescing of writes to the same address.
- wr_en must never have more than one bit set; X or multi-hot is a failure.

## Timing
- Latency: request pushed into an empty FIFO at edge k appears on out_valid/wr_en after edge k (same cycle for nothing; earliest sampling by register file at edge k+1).
- Throughput: 1 write/cycle sustained with out_ready held high.
- Reset values: count 0, both pointers 0, storage 0; out_valid 0, wr_en all 0, wr_addr 0, wr_data 0, in_ready 1.
- Reset mid-operation: buffered entries discarded, no write-enable pulse emitted while reset is asserted or on the first edge after deassertion.

## Configuration
- Macro: REGWRITE_ZERO_REG_DROP_EN.
- Defined: a request with in_addr == N-1 (XZR) is accepted (in_ready semantics unchanged) but not pushed; count and pointers unchanged; it never appears on wr_en. A simultaneous pop still proceeds.
- Undefined: address N-1 is handled like any other register and produces wr_en[N-1].

## Test plan
- Reset then single write: in_addr=5, in_data=64'hDEAD_BEEF, out_ready=1 -> next cycle out_valid=1, wr_en=32'h0000_0020, wr_data=64'hDEAD_BEEF; following cycle wr_en=0.
- Back-pressure: out_ready=0, push addr 1, 2 -> in_ready falls to 0 after second push, wr_en=32'h2 held; third request (addr 3) stalls; raise out_ready -> outputs 2, 4, 8 one per cycle in order.
- Streaming: 32 back-to-back writes addr 0..31, data=addr, out_ready=1 -> each one-hot bit seen exactly once, in order, no bubbles, count never exceeds 1.
- Push and pop at count 1: count 1 with head addr 7, push addr 9 while out_ready=1 -> head becomes 9 next cycle, count 1.
- Reset mid-operation: FIFO full (addr 4, 6), assert reset for 1 cycle -> wr_en=0, out_valid=0, in_ready=1 immediately; neither entry ever emitted.
- Zero register: with REGWRITE_ZERO_REG_DROP_EN, push addr 31 then addr 2 -> only wr_en=32'h4 appears; without the macro -> 32'h8000_0000 then 32'h4.
